// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper family: FSM states and Gray encoding.
package tt_sweep_pkg;

  localparam int unsigned CODE_MAX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Reflected-binary Gray encoding of a sweep index.
  function automatic logic [CODE_MAX_W-1:0] gray_enc(input logic [CODE_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sweep_index_gen.sv
// Sweep index counter: produces the registered input code for each vector and a last-code flag.
module sweep_index_gen
  import tt_sweep_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned GRAY_ORDER = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  output logic [N_IN-1:0] code,
  output logic            last
);

  localparam int unsigned IW       = N_IN + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'((2 ** N_IN) - 1);

  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_nxt;
  logic [N_IN-1:0] w_code_nxt;

  // Next index and its code in the selected sweep order.
  always_comb begin
    w_idx_nxt  = load ? '0 : (r_idx + IW'(1));
    w_code_nxt = (GRAY_ORDER != 0) ? N_IN'(gray_enc(CODE_MAX_W'(w_idx_nxt)))
                                   : N_IN'(w_idx_nxt);
  end

  // Index, code and last flag advance together on load or step; otherwise they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      code  <= '0;
      last  <= 1'b0;
    end else if (load || step) begin
      r_idx <= w_idx_nxt;
      code  <= w_code_nxt;
      last  <= (w_idx_nxt == LAST_IDX);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: drives every input code, waits a settle time, checks the
// DUT output against a truth table and records mismatch count and first failing code.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned            N_IN        = 3,
  parameter int unsigned            HOLD_CYCLES = 2,
  parameter int unsigned            GRAY_ORDER  = 0,
  parameter logic [(2**N_IN)-1:0]   EXPECTED    = 8'hE8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_code,
  output logic            first_err_vld
);

  localparam int unsigned   CW        = N_IN + 1;
  localparam logic [CW-1:0] ERR_MAX   = CW'(2 ** N_IN);
  localparam bit            HAS_HOLD  = (HOLD_CYCLES != 0);
  localparam logic [7:0]    HOLD_LAST = 8'((HOLD_CYCLES == 0) ? 0 : (HOLD_CYCLES - 1));

  state_t        r_state;
  logic [7:0]    r_settle;
  logic          w_start_ok;
  logic          w_mismatch;
  logic [CW-1:0] w_err_nxt;
  logic          w_step;
  logic          w_last;

  // Start acceptance, comparator and saturating error increment.
  always_comb begin
    w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_mismatch = (dut_y != EXPECTED[dut_in]);
    w_err_nxt  = err_count;
    if (w_mismatch && (err_count != ERR_MAX)) begin
      w_err_nxt = err_count + CW'(1);
    end
    w_step     = (r_state == ST_SAMPLE) && !w_last;
  end

  sweep_index_gen #(
    .N_IN       (N_IN),
    .GRAY_ORDER (GRAY_ORDER)
  ) u_index (
    .clk  (clk),
    .rst  (rst),
    .load (w_start_ok),
    .step (w_step),
    .code (dut_in),
    .last (w_last)
  );

  // Sweep FSM with settle counter and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_settle       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_code <= '0;
      first_err_vld  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state        <= HAS_HOLD ? ST_SETTLE : ST_SAMPLE;
            r_settle       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_code <= '0;
            first_err_vld  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_settle == HOLD_LAST) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + 8'd1;
          end
        end
        ST_SAMPLE: begin
          err_count <= w_err_nxt;
          r_settle  <= '0;
          if (w_mismatch && !first_err_vld) begin
            first_err_code <= dut_in;
            first_err_vld  <= 1'b1;
          end
          if (w_last) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_nxt == '0);
          end else begin
            r_state <= HAS_HOLD ? ST_SETTLE : ST_SAMPLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: four configurations (binary, Gray, zero hold, all-zero table)
// each driven by a majority/zero DUT model with a per-code fault mask.
module tb_truth_table_sweeper;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st [NI];
  logic [7:0] mk [NI];
  logic       dy [NI];

  wire [2:0] din [NI];
  wire       bsy [NI];
  wire       dn  [NI];
  wire       ps  [NI];
  wire [3:0] ec  [NI];
  wire [2:0] fc  [NI];
  wire       fv  [NI];

  int checks = 0;
  int errors = 0;

  logic [2:0] gray_seq [8];

  typedef struct {
    int         inst;
    logic [7:0] mask;
    int         e_err;
    int         e_first;
    bit         e_vld;
    bit         poke;
  } vec_t;

  vec_t tab [$];

  function automatic logic maj3(input logic [2:0] x);
    return ($countones(x) >= 2);
  endfunction

  // Block-under-test models: majority for instances 0..2, constant 0 for instance 3,
  // with mask bits inverting the output on chosen codes.
  assign dy[0] = maj3(din[0]) ^ mk[0][din[0]];
  assign dy[1] = maj3(din[1]) ^ mk[1][din[1]];
  assign dy[2] = maj3(din[2]) ^ mk[2][din[2]];
  assign dy[3] = mk[3][din[3]];

  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(2), .GRAY_ORDER(0), .EXPECTED(8'hE8)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .dut_y(dy[0]), .dut_in(din[0]), .busy(bsy[0]),
    .done(dn[0]), .pass(ps[0]), .err_count(ec[0]), .first_err_code(fc[0]), .first_err_vld(fv[0]));
  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(2), .GRAY_ORDER(1), .EXPECTED(8'hE8)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .dut_y(dy[1]), .dut_in(din[1]), .busy(bsy[1]),
    .done(dn[1]), .pass(ps[1]), .err_count(ec[1]), .first_err_code(fc[1]), .first_err_vld(fv[1]));
  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(0), .GRAY_ORDER(0), .EXPECTED(8'hE8)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .dut_y(dy[2]), .dut_in(din[2]), .busy(bsy[2]),
    .done(dn[2]), .pass(ps[2]), .err_count(ec[2]), .first_err_code(fc[2]), .first_err_vld(fv[2]));
  truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(2), .GRAY_ORDER(0), .EXPECTED(8'h00)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .dut_y(dy[3]), .dut_in(din[3]), .busy(bsy[3]),
    .done(dn[3]), .pass(ps[3]), .err_count(ec[3]), .first_err_code(fc[3]), .first_err_vld(fv[3]));

  function automatic int hold_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  // k-th code of the sweep: Gray instance follows the listed reflected-Gray sequence.
  function automatic int code_at(input int i, input int k);
    return (i == 1) ? int'(gray_seq[k]) : k;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input int i, input string nm);
    chk({nm, " dut_in"},         int'(din[i]), 0);
    chk({nm, " busy"},           int'(bsy[i]), 0);
    chk({nm, " done"},           int'(dn[i]),  0);
    chk({nm, " pass"},           int'(ps[i]),  0);
    chk({nm, " err_count"},      int'(ec[i]),  0);
    chk({nm, " first_err_code"}, int'(fc[i]),  0);
    chk({nm, " first_err_vld"},  int'(fv[i]),  0);
  endtask

  // One full sweep on instance i with fault mask m; checks per-cycle vector timing and results.
  task automatic sweep(input int i, input logic [7:0] m, input int e_err, input int e_first,
                       input bit e_vld, input bit poke, input string nm);
    int h;
    int total;
    h     = hold_of(i);
    total = 8 * (h + 1);
    mk[i] = m;
    @(negedge clk) st[i] = 1'b1;
    @(posedge clk);
    #1 st[i] = 1'b0;
    chk({nm, " v0 dut_in"},      int'(din[i]), code_at(i, 0));
    chk({nm, " v0 busy"},        int'(bsy[i]), 1);
    chk({nm, " v0 done"},        int'(dn[i]),  0);
    chk({nm, " start clr err"},  int'(ec[i]),  0);
    chk({nm, " start clr vld"},  int'(fv[i]),  0);
    for (int cyc = 1; cyc <= total; cyc++) begin
      if (poke && cyc == 4) st[i] = 1'b1;
      @(posedge clk);
      #1 st[i] = 1'b0;
      if (cyc < total) begin
        chk({nm, " dut_in seq"}, int'(din[i]), code_at(i, cyc / (h + 1)));
        chk({nm, " busy mid"},   int'(bsy[i]), 1);
        chk({nm, " done early"}, int'(dn[i]),  0);
      end else begin
        chk({nm, " done"},       int'(dn[i]),  1);
        chk({nm, " busy end"},   int'(bsy[i]), 0);
        chk({nm, " err_count"},  int'(ec[i]),  e_err);
        chk({nm, " first_vld"},  int'(fv[i]),  int'(e_vld));
        if (e_vld) chk({nm, " first_code"}, int'(fc[i]), e_first);
        chk({nm, " pass"},       int'(ps[i]),  (e_err == 0) ? 1 : 0);
        chk({nm, " dut_in hold"}, int'(din[i]), code_at(i, 7));
      end
    end
    @(posedge clk);
    #1;
    chk({nm, " done holds"}, int'(dn[i]), 1);
    chk({nm, " err holds"},  int'(ec[i]), e_err);
  endtask

  initial begin
    gray_seq[0] = 3'd0; gray_seq[1] = 3'd1; gray_seq[2] = 3'd3; gray_seq[3] = 3'd2;
    gray_seq[4] = 3'd6; gray_seq[5] = 3'd7; gray_seq[6] = 3'd5; gray_seq[7] = 3'd4;
    for (int i = 0; i < NI; i++) begin
      st[i] = 1'b0;
      mk[i] = 8'h00;
    end

    // Reset values, with start held high to confirm rst wins.
    rst   = 1'b1;
    st[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk_reset(i, "reset");
    st[0] = 1'b0;
    rst   = 1'b0;

    // Hand-derived vectors: {inst, mask, err, first, vld, poke}.
    tab.push_back('{0, 8'h00, 0, 0, 1'b0, 1'b0});
    tab.push_back('{0, 8'h60, 2, 5, 1'b1, 1'b0});
    tab.push_back('{1, 8'h00, 0, 0, 1'b0, 1'b0});
    tab.push_back('{1, 8'h60, 2, 6, 1'b1, 1'b0});
    tab.push_back('{1, 8'h0C, 2, 3, 1'b1, 1'b0});
    tab.push_back('{2, 8'h00, 0, 0, 1'b0, 1'b1});
    tab.push_back('{2, 8'h81, 2, 0, 1'b1, 1'b1});
    tab.push_back('{3, 8'hFF, 8, 0, 1'b1, 1'b0});
    tab.push_back('{3, 8'hFF, 8, 0, 1'b1, 1'b0});
    tab.push_back('{0, 8'h80, 1, 7, 1'b1, 1'b0});
    foreach (tab[t]) begin
      sweep(tab[t].inst, tab[t].mask, tab[t].e_err, tab[t].e_first, tab[t].e_vld,
            tab[t].poke, $sformatf("tab%0d", t));
    end

    // Reset at the 4th vector aborts the sweep and clears results.
    mk[0] = 8'h01;
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort 4th vector", int'(din[0]), 3);
    chk("abort err before", int'(ec[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset(0, "abort");
    rst = 1'b0;
    sweep(0, 8'h00, 0, 0, 1'b0, 1'b0, "post-abort");

    // Random fault masks against a model: mismatches are exactly the masked codes,
    // the first one being the earliest masked code in sweep order.
    for (int r = 0; r < 24; r++) begin
      int         i;
      logic [7:0] m;
      int         e_err;
      int         e_first;
      bit         e_vld;
      i       = int'($urandom_range(0, NI - 1));
      m       = 8'($urandom);
      e_err   = 0;
      e_first = 0;
      e_vld   = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (m[code_at(i, k)]) begin
          if (!e_vld) e_first = code_at(i, k);
          e_vld = 1'b1;
          e_err++;
        end
      end
      sweep(i, m, e_err, e_first, e_vld, r[0], $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
